// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU (producer), alu_result_buffer and its consumer.
// The slave modport is the buffer's view; master is the surrounding environment.
interface alu_result_buffer_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic [2*N-1:0]   in_result;
    logic [1:0]       in_op_code;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_result;
    logic [1:0]       out_op_code;

    modport master (
        output in_valid, in_result, in_op_code, out_ready,
        input  in_ready, out_valid, out_result, out_op_code
    );

    modport slave (
        input  in_valid, in_result, in_op_code, out_ready,
        output in_ready, out_valid, out_result, out_op_code
    );
endinterface

// File: rtl/alu_result_buffer.sv
// First-word-fall-through result FIFO behind the ALU with sticky overflow status.
// Optional running pop accumulator enabled by defining ALU_RES_ACC_EN.
module alu_result_buffer #(
    parameter  int N     = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_result_buffer_if.slave   bus,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 empty,
    output logic                 overflow,
    input  logic                 clr_ovf
`ifdef ALU_RES_ACC_EN
    ,
    input  logic                 acc_clr,
    output logic [2*N+7:0]       acc_sum,
    output logic [15:0]          acc_cnt
`endif
);
    localparam int              RW      = 2 * N;
    localparam int              DW      = RW + 2;
    localparam logic [AW:0]     DEPTH_C = (AW + 1)'(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_head;
    logic          r_ovf;

    logic          w_full;
    logic          w_empty;
    logic          w_out_valid;
    logic          w_out_fire;
    logic          w_push;
    logic          w_drop;
    logic [DW-1:0] w_in_data;
    logic [AW-1:0] w_next_rd;
    logic [AW:0]   w_next_count;
    logic          w_head_from_input;

    // Status comes only from registered occupancy, never from in_valid.
    assign w_full      = (r_count == DEPTH_C);
    assign w_empty     = (r_count == '0);
    assign w_out_valid = !w_empty;
    assign w_out_fire  = w_out_valid && bus.out_ready;
    assign w_push      = bus.in_valid && (!w_full || w_out_fire);
    assign w_drop      = bus.in_valid && w_full && !w_out_fire;
    assign w_in_data   = {bus.in_op_code, bus.in_result};
    assign w_next_rd   = r_rd_ptr + AW'(w_out_fire);

    // The incoming word becomes the head only when nothing older survives this edge.
    assign w_head_from_input = w_push && (r_count == (AW + 1)'(w_out_fire));

    always_comb begin
        w_next_count = r_count;
        unique case ({w_push, w_out_fire})
            2'b10:   w_next_count = r_count + 1'b1;
            2'b01:   w_next_count = r_count - 1'b1;
            default: w_next_count = r_count;
        endcase
    end

    // NOTE: storage has no reset; pointers and count define which words are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_data;
        end
    end

    // NOTE: all state here uses <= so every read sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_next_rd;
            r_count  <= w_next_count;
            // Head register holds its last value while the FIFO is empty.
            if (w_next_count != '0) begin
                r_head <= w_head_from_input ? w_in_data : r_mem[w_next_rd];
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = !w_full || w_out_fire;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_result  = r_head[RW-1:0];
    assign bus.out_op_code = r_head[DW-1 -: 2];
    assign count           = r_count;
    assign full            = w_full;
    assign empty           = w_empty;
    assign overflow        = r_ovf;

`ifdef ALU_RES_ACC_EN
    logic [RW+7:0] r_acc_sum;
    logic [15:0]   r_acc_cnt;

    // A clear coinciding with a pop restarts the totals from that pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc_sum <= '0;
            r_acc_cnt <= '0;
        end else if (w_out_fire) begin
            if (acc_clr) begin
                r_acc_sum <= {8'd0, bus.out_result};
                r_acc_cnt <= 16'd1;
            end else begin
                r_acc_sum <= r_acc_sum + {8'd0, bus.out_result};
                r_acc_cnt <= r_acc_cnt + 16'd1;
            end
        end else if (acc_clr) begin
            r_acc_sum <= '0;
            r_acc_cnt <= '0;
        end
    end

    assign acc_sum = r_acc_sum;
    assign acc_cnt = r_acc_cnt;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer: directed scenarios plus randomized traffic
// compared against a queue-based model. Define ALU_RES_ACC_EN to cover the accumulator.
module tb_alu_result_buffer;
    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int RW    = 2 * N;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr_ovf;
    logic          acc_clr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
`ifdef ALU_RES_ACC_EN
    logic [RW+7:0] acc_sum;
    logic [15:0]   acc_cnt;
`endif

    alu_result_buffer_if #(.N(N)) bus ();

    alu_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
`ifdef ALU_RES_ACC_EN
        ,
        .acc_clr  (acc_clr),
        .acc_sum  (acc_sum),
        .acc_cnt  (acc_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [1:0]    op;
        logic [RW-1:0] res;
    } entry_t;

    // Reference model: contents as a queue, plus sticky flag, last head and totals.
    entry_t        mq[$];
    bit            m_ovf;
    entry_t        m_head;
    logic [RW+7:0] m_sum;
    logic [15:0]   m_cnt;

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_head = '0;
        m_sum  = '0;
        m_cnt  = '0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic step(input bit iv, input logic [RW-1:0] res, input logic [1:0] op,
                        input bit ordy, input bit clr, input bit aclr);
        bit     fire, mfull, push, drop;
        entry_t popped;
        bus.in_valid   = iv;
        bus.in_result  = res;
        bus.in_op_code = op;
        bus.out_ready  = ordy;
        clr_ovf        = clr;
        acc_clr        = aclr;
        @(posedge clk);
        fire  = (mq.size() != 0) && ordy;
        mfull = (mq.size() == DEPTH);
        push  = iv && (!mfull || fire);
        drop  = iv && mfull && !fire;
        if (fire) begin
            popped = mq.pop_front();
            if (aclr) begin
                m_sum = {8'd0, popped.res};
                m_cnt = 16'd1;
            end else begin
                m_sum = m_sum + {8'd0, popped.res};
                m_cnt = m_cnt + 16'd1;
            end
        end else if (aclr) begin
            m_sum = '0;
            m_cnt = '0;
        end
        if (push) mq.push_back({op, res});
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (mq.size() != 0) m_head = mq[0];
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, '0, 2'd0, ordy, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_result = '0; bus.in_op_code = '0;
        bus.out_ready = 1'b0; clr_ovf = 1'b0; acc_clr = 1'b0;
        model_reset();
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        n_checks++; if (full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %0b expected 0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        n_checks++; if (count !== '0) begin n_errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_checks++; if (bus.out_result !== '0 || bus.out_op_code !== '0) begin n_errors++; $display("FAIL reset_out_data: got %0h/%0d expected 0/0", bus.out_result, bus.out_op_code); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic_order();
        logic [RW-1:0] vals [3];
        vals[0] = 16'h0010; vals[1] = 16'h00FF; vals[2] = 16'hFE01;
        for (int i = 0; i < 3; i++) step(1'b1, vals[i], 2'(i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (count !== 4'd3) begin n_errors++; $display("FAIL basic_count: got %0d expected 3", count); end
            n_checks++; if (bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %0b expected 1", bus.out_valid); end
            n_checks++; if (bus.out_result !== 16'h0010 || bus.out_op_code !== 2'd0) begin n_errors++; $display("FAIL basic_hold: got %0h/%0d expected 0010/0", bus.out_result, bus.out_op_code); end
            idle(1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.out_result !== vals[i] || bus.out_op_code !== 2'(i)) begin n_errors++; $display("FAIL basic_pop%0d: got %0h/%0d expected %0h/%0d", i, bus.out_result, bus.out_op_code, vals[i], i); end
            idle(1'b1);
        end
        n_checks++; if (empty !== 1'b1 || bus.out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_empty: got empty=%0b valid=%0b expected 1/0", empty, bus.out_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'h0100 + 16'(i), 2'(i), 1'b0, 1'b0, 1'b0);
        n_checks++; if (full !== 1'b1 || count !== 4'd8) begin n_errors++; $display("FAIL ovf_full: got full=%0b count=%0d expected 1/8", full, count); end
        bus.in_valid = 1'b1; bus.out_ready = 1'b0; #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL ovf_in_ready: got %0b expected 0", bus.in_ready); end
        step(1'b1, 16'hDEAD, 2'd3, 1'b0, 1'b0, 1'b0);
        n_checks++; if (overflow !== 1'b1 || count !== 4'd8) begin n_errors++; $display("FAIL ovf_drop: got ovf=%0b count=%0d expected 1/8", overflow, count); end
        n_checks++; if (bus.out_result !== 16'h0100) begin n_errors++; $display("FAIL ovf_head: got %0h expected 0100", bus.out_result); end
        step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
        step(1'b1, 16'hBEEF, 2'd1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set_wins: got %0b expected 1", overflow); end
        step(1'b0, '0, 2'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (overflow !== 1'(m_ovf)) begin n_errors++; $display("FAIL ovf_clear2: got %0b expected %0b", overflow, m_ovf); end
    endtask

    task automatic test_full_stream();
        logic [RW-1:0] data = 16'h2000;
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== m_head.res || bus.out_op_code !== m_head.op) begin n_errors++; $display("FAIL stream_head%0d: got v=%0b %0h/%0d expected 1 %0h/%0d", i, bus.out_valid, bus.out_result, bus.out_op_code, m_head.res, m_head.op); end
            step(1'b1, data, data[1:0], 1'b1, 1'b0, 1'b0);
            data = data + 1'b1;
            n_checks++; if (count !== 4'd8 || overflow !== 1'b0) begin n_errors++; $display("FAIL stream_count%0d: got count=%0d ovf=%0b expected 8/0", i, count, overflow); end
        end
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
            n_checks++; if (bus.out_result !== m_head.res) begin n_errors++; $display("FAIL drain_data: got %0h expected %0h", bus.out_result, m_head.res); end
            idle(1'b1);
        end
        n_checks++; if (empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_empty_push_pop();
        step(1'b1, 16'h5A5A, 2'd2, 1'b1, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd1 || bus.out_valid !== 1'b1) begin n_errors++; $display("FAIL epp_count: got count=%0d valid=%0b expected 1/1", count, bus.out_valid); end
        n_checks++; if (bus.out_result !== 16'h5A5A || bus.out_op_code !== 2'd2) begin n_errors++; $display("FAIL epp_data: got %0h/%0d expected 5a5a/2", bus.out_result, bus.out_op_code); end
        idle(1'b1);
        n_checks++; if (empty !== 1'b1 || bus.out_result !== 16'h5A5A) begin n_errors++; $display("FAIL epp_hold_last: got empty=%0b data=%0h expected 1/5a5a", empty, bus.out_result); end
    endtask

    task automatic test_acc();
`ifdef ALU_RES_ACC_EN
        step(1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (acc_sum !== '0 || acc_cnt !== '0) begin n_errors++; $display("FAIL acc_clear: got %0h/%0d expected 0/0", acc_sum, acc_cnt); end
        for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF, 2'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        n_checks++; if (acc_sum !== 24'h03FFFC || acc_cnt !== 16'd4) begin n_errors++; $display("FAIL acc_sum4: got %0h/%0d expected 03fffc/4", acc_sum, acc_cnt); end
        step(1'b1, 16'h0005, 2'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 2'd0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (acc_sum !== 24'd5 || acc_cnt !== 16'd1) begin n_errors++; $display("FAIL acc_clr_pop: got %0h/%0d expected 5/1", acc_sum, acc_cnt); end
`endif
    endtask

    task automatic test_random();
        int pv [4];
        int pr [4];
        pv[0] = 80; pv[1] = 50; pv[2] = 20; pv[3] = 95;
        pr[0] = 30; pr[1] = 50; pr[2] = 85; pr[3] = 60;
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 100; c++) begin
                bit            iv, ordy, clr, aclr;
                logic [RW-1:0] res;
                logic [1:0]    op;
                iv   = ($urandom_range(99) < pv[ph]);
                ordy = ($urandom_range(99) < pr[ph]);
                clr  = ($urandom_range(99) < 5);
                aclr = ($urandom_range(99) < 3);
                res  = RW'($urandom);
                op   = 2'($urandom);
                bus.out_ready = ordy; #1;
                n_checks++; if (bus.in_ready !== ((mq.size() != DEPTH) || (mq.size() != 0 && ordy))) begin n_errors++; $display("FAIL rnd_in_ready: got %0b size=%0d ready=%0b", bus.in_ready, mq.size(), ordy); end
                step(iv, res, op, ordy, clr, aclr);
                n_checks++; if (count !== (AW + 1)'(mq.size())) begin n_errors++; $display("FAIL rnd_count: got %0d expected %0d", count, mq.size()); end
                n_checks++; if (bus.out_valid !== (mq.size() != 0) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin n_errors++; $display("FAIL rnd_flags: got v=%0b e=%0b f=%0b size=%0d", bus.out_valid, empty, full, mq.size()); end
                n_checks++; if (overflow !== 1'(m_ovf)) begin n_errors++; $display("FAIL rnd_overflow: got %0b expected %0b", overflow, m_ovf); end
                n_checks++; if (bus.out_result !== m_head.res || bus.out_op_code !== m_head.op) begin n_errors++; $display("FAIL rnd_data: got %0h/%0d expected %0h/%0d", bus.out_result, bus.out_op_code, m_head.res, m_head.op); end
`ifdef ALU_RES_ACC_EN
                n_checks++; if (acc_sum !== m_sum || acc_cnt !== m_cnt) begin n_errors++; $display("FAIL rnd_acc: got %0h/%0d expected %0h/%0d", acc_sum, acc_cnt, m_sum, m_cnt); end
`endif
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) idle(1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 16'h0300 + 16'(i), 2'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        n_checks++; if (count !== 4'd5 || overflow !== 1'b1) begin n_errors++; $display("FAIL areset_pre: got count=%0d ovf=%0b expected 5/1", count, overflow); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (count !== '0 || bus.out_valid !== 1'b0 || overflow !== 1'b0 || empty !== 1'b1) begin n_errors++; $display("FAIL areset_async: got count=%0d valid=%0b ovf=%0b empty=%0b expected 0/0/0/1", count, bus.out_valid, overflow, empty); end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 16'h0042, 2'd1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (count !== 4'd1 || bus.out_result !== 16'h0042) begin n_errors++; $display("FAIL areset_restart: got count=%0d data=%0h expected 1/0042", count, bus.out_result); end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_overflow();
        test_full_stream();
        test_empty_push_pop();
        test_acc();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
